mips_data_bus_responder: RTL and testbench

Responder end of the CPU's Harvard data bus: decodes `data_address`, serves combinational reads and single-cycle writes to a byte-enabled word RAM, and exposes a small MMIO page with a free-running cycle counter, a status register and a transmit byte FIFO drained through a valid/ready port. It sits between `mips_cpu_harvard`'s data port and the test benches or top level, replacing the flat data RAM when the CPU needs observable I/O.

---
 rtl/data_bus_pkg.sv | 39 +++
 rtl/data_bus_tx_fifo.sv | 79 +++++++
 rtl/mips_data_bus_responder.sv | 205 ++++++++++++++++++++
 tb/tb_mips_data_bus_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_pkg
// Shared constants and types for the MIPS data-bus responder:
//   - MMIO register byte addresses (COUNTER, TX, STATUS)
//   - STATUS register bit positions
//   - region-select enum produced by the address decoder
//   - byte-lane merge helper used for byte-enabled register/RAM updates
// -----------------------------------------------------------------------------
package data_bus_pkg;

  localparam logic [31:0] ADDR_COUNTER = 32'hFFFF_FFF0;
  localparam logic [31:0] ADDR_TX      = 32'hFFFF_FFF4;
  localparam logic [31:0] ADDR_STATUS  = 32'hFFFF_FFF8;

  localparam int unsigned ST_OVERFLOW = 31;
  localparam int unsigned ST_EMPTY    = 9;
  localparam int unsigned ST_FULL     = 8;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_COUNTER,
    SEL_TX,
    SEL_STATUS,
    SEL_NONE
  } bus_sel_e;

  // Replace the byte lanes of old_word selected by be with lanes of new_word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int unsigned n = 0; n < 4; n++) begin
      if (be[n]) merged[8*n +: 8] = new_word[8*n +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_bus_tx_fifo.sv
// -----------------------------------------------------------------------------
// data_bus_tx_fifo
// Byte FIFO with read/write pointers and an explicit occupancy counter.
// A push into a full FIFO is accepted only when a pop happens the same cycle;
// a pop from an empty FIFO is ignored. The head output reads 0 when empty.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset (empties the FIFO)
//   push_i       in   push request
//   push_data_i  in   8   byte to push
//   pop_i        in   pop request
//   head_o       out  8   head entry (0 when empty)
//   full_o       out  count == DEPTH
//   empty_o      out  count == 0
//   count_o      out  CW  occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module data_bus_tx_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [7:0]    push_data_i,
  input  logic          pop_i,
  output logic [7:0]    head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mips_data_bus_responder.sv
// -----------------------------------------------------------------------------
// mips_data_bus_responder
// Responder for the Harvard CPU data port: byte-enabled word RAM with
// combinational reads, plus an MMIO page:
//   0xFFFF_FFF0 COUNTER  free-running cycle counter (writable, byte lanes)
//   0xFFFF_FFF4 TX       write-only byte push into the transmit FIFO
//   0xFFFF_FFF8 STATUS   {overflow[31], empty[9], full[8], occupancy[7:0]}
// Any other address is unmapped: reads return 0, writes are dropped, and
// bus_error pulses for the cycle after the access.
//
// Build option: define DATA_BUS_COUNTER_EN to implement the COUNTER register;
// otherwise COUNTER stays mapped but reads 0 and ignores writes.
//
// Ports:
//   clk              in   clock, rising edge
//   reset            in   asynchronous active-high reset
//   data_address     in   32  byte address, bits [1:0] ignored
//   data_write       in   write strobe (commits at next rising edge)
//   data_read        in   read strobe
//   data_writedata   in   32  write data
//   data_byteenable  in   4   lane enables, bit n -> bits [8n+7:8n]
//   data_readdata    out  32  combinational read data
//   tx_valid         out  FIFO non-empty
//   tx_data          out  8   FIFO head byte
//   tx_ready         in   sink takes head byte this cycle
//   bus_error        out  one-cycle pulse after an unmapped access
// -----------------------------------------------------------------------------
module mips_data_bus_responder
  import data_bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE      = 32'h0000_0000,
  parameter int unsigned RAM_WORDS     = 1024,
  parameter string       RAM_INIT_FILE = "",
  parameter int unsigned TX_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic [31:0] data_readdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        bus_error
);

  localparam int unsigned IDXW     = $clog2(RAM_WORDS);
  localparam int unsigned FCW      = $clog2(TX_DEPTH) + 1;
  localparam logic [32:0] RAM_SPAN = 33'(RAM_WORDS) << 2;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]     addr_w;
  logic [32:0]     ram_off;
  logic            ram_hit;
  logic [IDXW-1:0] ram_idx;
  bus_sel_e        sel;
  logic            unused_addr_lsbs;

  assign addr_w           = {data_address[31:2], 2'b00};
  assign unused_addr_lsbs = ^data_address[1:0];

  // 33-bit offset so a RAM window ending at the top of the address space
  // cannot wrap and alias low addresses.
  assign ram_off = {1'b0, addr_w} - {1'b0, RAM_BASE};
  assign ram_hit = (addr_w >= RAM_BASE) && (ram_off < RAM_SPAN);
  assign ram_idx = ram_off[IDXW+1:2];

  always_comb begin
    sel = SEL_NONE;
    if (ram_hit)                    sel = SEL_RAM;
    else if (addr_w == ADDR_COUNTER) sel = SEL_COUNTER;
    else if (addr_w == ADDR_TX)      sel = SEL_TX;
    else if (addr_w == ADDR_STATUS)  sel = SEL_STATUS;
  end

  // ---------------------------------------------------------------------------
  // Word RAM (not cleared by reset)
  // ---------------------------------------------------------------------------
  logic [31:0] ram_q [RAM_WORDS];
  logic        ram_we;

  assign ram_we = data_write && (sel == SEL_RAM) && !reset;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (data_byteenable[n]) ram_q[ram_idx][8*n +: 8] <= data_writedata[8*n +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------------------
  logic [31:0] counter_rd;

`ifdef DATA_BUS_COUNTER_EN
  logic [31:0] counter_q, counter_d;

  // A bus write replaces the increment for that cycle; unwritten lanes hold.
  always_comb begin
    counter_d = counter_q + 32'd1;
    if (data_write && (sel == SEL_COUNTER)) begin
      counter_d = lane_merge(counter_q, data_writedata, data_byteenable);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) counter_q <= '0;
    else       counter_q <= counter_d;
  end

  assign counter_rd = counter_q;
`else
  assign counter_rd = '0;
`endif

  // ---------------------------------------------------------------------------
  // Transmit FIFO and sticky overflow
  // ---------------------------------------------------------------------------
  logic           tx_push, tx_pop;
  logic           fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_count;
  logic [7:0]     fifo_head;
  logic           overflow_q, overflow_d;
  logic           ovf_clear;

  assign tx_push   = data_write && (sel == SEL_TX) && data_byteenable[0];
  assign tx_pop    = tx_valid && tx_ready;
  assign ovf_clear = data_write && (sel == SEL_STATUS) &&
                     data_byteenable[3] && data_writedata[31];

  data_bus_tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk         (clk),
    .rst         (reset),
    .push_i      (tx_push),
    .push_data_i (data_writedata[7:0]),
    .pop_i       (tx_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_head;

  // A push into a full FIFO is only dropped when no pop frees a slot.
  always_comb begin
    overflow_d = overflow_q;
    if (tx_push && fifo_full && !tx_pop) overflow_d = 1'b1;
    if (ovf_clear)                       overflow_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Bus error pulse
  // ---------------------------------------------------------------------------
  logic bus_error_q, bus_error_d;

  assign bus_error_d = (data_read || data_write) && (sel == SEL_NONE);
  assign bus_error   = bus_error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      bus_error_q <= bus_error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] status_w;

  always_comb begin
    status_w              = '0;
    status_w[ST_OVERFLOW] = overflow_q;
    status_w[ST_EMPTY]    = fifo_empty;
    status_w[ST_FULL]     = fifo_full;
    status_w[7:0]         = 8'(fifo_count);
  end

  always_comb begin
    data_readdata = '0;
    if (data_read) begin
      case (sel)
        SEL_RAM:     data_readdata = ram_q[ram_idx];
        SEL_COUNTER: data_readdata = counter_rd;
        SEL_STATUS:  data_readdata = status_w;
        default:     data_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_data_bus_responder.sv
module tb_mips_data_bus_responder;

  localparam logic [31:0] A_CNT  = 32'hFFFF_FFF0;
  localparam logic [31:0] A_TX   = 32'hFFFF_FFF4;
  localparam logic [31:0] A_STAT = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_data_bus_responder #(
    .RAM_BASE  (32'h0000_0000),
    .RAM_WORDS (1024),
    .TX_DEPTH  (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .data_address    (data_address),
    .data_write      (data_write),
    .data_read       (data_read),
    .data_writedata  (data_writedata),
    .data_byteenable (data_byteenable),
    .data_readdata   (data_readdata),
    .tx_valid        (tx_valid),
    .tx_data         (tx_data),
    .tx_ready        (tx_ready),
    .bus_error       (bus_error)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_berr;
  } vec_t;

  vec_t vecs[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd, input logic [3:0] be);
    data_address    = a;
    data_read       = rd;
    data_write      = wr;
    data_writedata  = wd;
    data_byteenable = be;
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    drive(A_TX, 1'b0, 1'b1, {24'h0, b}, 4'b0001);
    tick();
    idle();
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(a, 1'b1, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    check32(name, data_readdata, exp);
    tick();
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // name, addr, rd, wr, wdata, be, expected readdata, expected bus_error
    vecs.push_back('{"ram_wr_full",   32'h0000_0008, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b1111, 32'h0,          1'b0});
    vecs.push_back('{"ram_rd_full",   32'h0000_0008, 1'b1, 1'b0, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{"ram_wr_lane1",  32'h0000_0008, 1'b0, 1'b1, 32'h0000_5500, 4'b0010, 32'h0,          1'b0});
    vecs.push_back('{"ram_rd_lane1",  32'h0000_0008, 1'b1, 1'b0, 32'h0,         4'b0000, 32'hDEAD_55EF, 1'b0});
    vecs.push_back('{"ram_rd_lsbs",   32'h0000_000B, 1'b1, 1'b0, 32'h0,         4'b0000, 32'hDEAD_55EF, 1'b0});
    vecs.push_back('{"ram_wr_10",     32'h0000_0010, 1'b0, 1'b1, 32'h1111_1111, 4'b1111, 32'h0,          1'b0});
    vecs.push_back('{"ram_rdwr_old",  32'h0000_0010, 1'b1, 1'b1, 32'h2222_2222, 4'b1111, 32'h1111_1111, 1'b0});
    vecs.push_back('{"ram_rd_new",    32'h0000_0010, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h2222_2222, 1'b0});
    vecs.push_back('{"ram_wr_last",   32'h0000_0FFC, 1'b0, 1'b1, 32'hA5A5_A5A5, 4'b1111, 32'h0,          1'b0});
    vecs.push_back('{"ram_rd_last",   32'h0000_0FFC, 1'b1, 1'b0, 32'h0,         4'b0000, 32'hA5A5_A5A5, 1'b0});
    vecs.push_back('{"rd_past_ram",   32'h0000_1000, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,          1'b0});
    vecs.push_back('{"berr_after_rd", 32'h0000_0008, 1'b1, 1'b0, 32'h0,         4'b0000, 32'hDEAD_55EF, 1'b1});
    vecs.push_back('{"unmapped_rd",   32'h2000_0000, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,          1'b0});
    vecs.push_back('{"berr_pulse",    32'h0000_0008, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,          1'b1});
    vecs.push_back('{"berr_one_cyc",  32'h0000_0000, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,          1'b0});
    vecs.push_back('{"unmapped_wr",   32'h2000_0000, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b1111, 32'h0,          1'b0});
    vecs.push_back('{"berr_after_wr", 32'h0000_0010, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h2222_2222, 1'b1});
    vecs.push_back('{"tx_rd_zero",    A_TX,          1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,          1'b0});
    vecs.push_back('{"status_empty",  A_STAT,        1'b1, 1'b0, 32'h0,         4'b0000, 32'h0000_0200, 1'b0});
    vecs.push_back('{"mmio_hole_rd",  32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,          1'b0});
    vecs.push_back('{"berr_hole",     32'h0000_0000, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,          1'b1});

    reset    = 1'b1;
    tx_ready = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_tx_valid",  {31'h0, tx_valid},  32'h0);
    check32("rst_tx_data",   {24'h0, tx_data},   32'h0);
    check32("rst_bus_error", {31'h0, bus_error}, 32'h0);
    check32("rst_rdata_idle", data_readdata,     32'h0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, vecs[i].be);
      @(negedge clk);
      check32({vecs[i].name, "_rdata"}, data_readdata, vecs[i].exp_rdata);
      check32({vecs[i].name, "_berr"}, {31'h0, bus_error}, {31'h0, vecs[i].exp_berr});
      tick();
    end
    idle();

    // Counter
`ifdef DATA_BUS_COUNTER_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    read_check("cnt_after_10", A_CNT, 32'd10);
    drive(A_CNT, 1'b0, 1'b1, 32'hFFFF_FFFE, 4'b1111);
    tick();
    drive(A_CNT, 1'b1, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    check32("cnt_loaded", data_readdata, 32'hFFFF_FFFE);
    tick();
    tick();
    @(negedge clk);
    check32("cnt_wrap", data_readdata, 32'h0);
    tick();
    idle();
`else
    repeat (10) tick();
    read_check("cnt_disabled_rd", A_CNT, 32'h0);
    drive(A_CNT, 1'b0, 1'b1, 32'hFFFF_FFFE, 4'b1111);
    tick();
    read_check("cnt_disabled_wr", A_CNT, 32'h0);
    @(negedge clk);
    check32("cnt_no_berr", {31'h0, bus_error}, 32'h0);
    tick();
`endif

    // Basic push and drain; a TX write without lane 0 is ignored
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    drive(A_TX, 1'b0, 1'b1, 32'h0000_0099, 4'b1110);
    tick();
    drive(A_STAT, 1'b1, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    check32("tx3_status", data_readdata, 32'h0000_0003);
    check32("tx3_valid", {31'h0, tx_valid}, 32'h1);
    check32("tx3_head", {24'h0, tx_data}, 32'h41);
    tick();
    idle();
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("tx3_drain_valid", {31'h0, tx_valid}, 32'h1);
      check32("tx3_drain_data", {24'h0, tx_data}, 32'h41 + i);
      tick();
    end
    tx_ready = 1'b0;
    read_check("tx3_status_after", A_STAT, 32'h0000_0200);

    // Overflow: 9 pushes into depth 8
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    read_check("ovf_status", A_STAT, 32'h8000_0108);
    drive(A_STAT, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0111);
    tick();
    read_check("ovf_no_clear_lane", A_STAT, 32'h8000_0108);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check32("ovf_drain_data", {24'h0, tx_data}, 32'(i));
      tick();
    end
    tx_ready = 1'b0;
    @(negedge clk);
    check32("ovf_ninth_absent", {31'h0, tx_valid}, 32'h0);
    tick();
    read_check("ovf_sticky", A_STAT, 32'h8000_0200);
    drive(A_STAT, 1'b0, 1'b1, 32'h8000_0000, 4'b1000);
    tick();
    read_check("ovf_cleared", A_STAT, 32'h0000_0200);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    read_check("full_status", A_STAT, 32'h0000_0108);
    drive(A_TX, 1'b0, 1'b1, 32'h0000_005A, 4'b0001);
    tx_ready = 1'b1;
    @(negedge clk);
    check32("full_pp_head", {24'h0, tx_data}, 32'h10);
    tick();
    tx_ready = 1'b0;
    idle();
    read_check("full_pp_status", A_STAT, 32'h0000_0108);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check32("full_pp_drain", {24'h0, tx_data}, (i == 7) ? 32'h5A : 32'h11 + i);
      tick();
    end
    tx_ready = 1'b0;
    @(negedge clk);
    check32("full_pp_empty", {31'h0, tx_valid}, 32'h0);
    tick();

    // Empty FIFO with push and ready: push only
    tx_ready = 1'b1;
    drive(A_TX, 1'b0, 1'b1, 32'h0000_0077, 4'b0001);
    @(negedge clk);
    check32("empty_pp_valid0", {31'h0, tx_valid}, 32'h0);
    tick();
    idle();
    @(negedge clk);
    check32("empty_pp_valid1", {31'h0, tx_valid}, 32'h1);
    check32("empty_pp_data", {24'h0, tx_data}, 32'h77);
    tick();
    tx_ready = 1'b0;
    @(negedge clk);
    check32("empty_pp_drained", {31'h0, tx_valid}, 32'h0);
    tick();

    // Asynchronous reset with 3 bytes queued; RAM write during reset is lost
    push_byte(8'h31);
    push_byte(8'h32);
    push_byte(8'h33);
    @(negedge clk);
    check32("prerst_valid", {31'h0, tx_valid}, 32'h1);
    tick();
    drive(32'h0000_0008, 1'b0, 1'b1, 32'h1234_5678, 4'b1111);
    #2;
    reset = 1'b1;
    #1;
    check32("async_rst_valid", {31'h0, tx_valid}, 32'h0);
    check32("async_rst_data", {24'h0, tx_data}, 32'h0);
    tick();
    idle();
    reset = 1'b0;
    read_check("postrst_status", A_STAT, 32'h0000_0200);
    read_check("postrst_ram", 32'h0000_0008, 32'hDEAD_55EF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
